// File: rtl/apb_timer_pkg.sv
// ----------------------------------------------------------------------------
// apb_timer_pkg
// Shared definitions for the APB timer peripheral: register offsets, CTRL and
// STATUS bit positions, the packed CTRL register type and a byte-lane merge
// helper used wherever a PSTRB-qualified write updates a 32-bit register.
// No ports (package).
// ----------------------------------------------------------------------------
package apb_timer_pkg;

    // Register offsets within the peripheral window
    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_LOAD   = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    // CTRL / STATUS bit positions as seen on the bus
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AR_BIT    = 1;
    localparam int CTRL_IRQ_BIT   = 2;
    localparam int CTRL_PS_LSB    = 8;
    localparam int STATUS_EXP_BIT = 0;

    typedef struct packed {
        logic [7:0] prescale;
        logic       irqEn;
        logic       autoReload;
        logic       en;
    } ctrl_t;

    // Replace only the byte lanes whose strobe is set
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = newVal[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Bus view of CTRL; unimplemented bits read as zero
    function automatic logic [31:0] ctrlToWord(input ctrl_t c);
        logic [31:0] w;
        w                    = '0;
        w[CTRL_EN_BIT]       = c.en;
        w[CTRL_AR_BIT]       = c.autoReload;
        w[CTRL_IRQ_BIT]      = c.irqEn;
        w[CTRL_PS_LSB +: 8]  = c.prescale;
        return w;
    endfunction

endpackage

// File: rtl/apb_timer_core.sv
// ----------------------------------------------------------------------------
// apb_timer_core
// Prescaler, 32-bit down-counter and sticky EXPIRED flag of the APB timer.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   en_i, autoReload_i   current CTRL.EN / CTRL.AUTO_RELOAD
//   prescale_i           current CTRL.PRESCALE
//   load_i               current LOAD register (reload source)
//   loadStrb_i           byte lanes of a LOAD write committing this cycle
//   loadWdata_i          write data for that LOAD write
//   enRise_i             CTRL write is turning EN on this cycle
//   expiredClr_i         W1C of STATUS.EXPIRED this cycle
//   count_o              current COUNT
//   expired_o            sticky EXPIRED flag
//   enClr_o              one-shot expiry: CTRL.EN must clear this cycle
// ----------------------------------------------------------------------------
module apb_timer_core
    import apb_timer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        autoReload_i,
    input  logic [7:0]  prescale_i,
    input  logic [31:0] load_i,
    input  logic [3:0]  loadStrb_i,
    input  logic [31:0] loadWdata_i,
    input  logic        enRise_i,
    input  logic        expiredClr_i,
    output logic [31:0] count_o,
    output logic        expired_o,
    output logic        enClr_o
);

    logic [7:0]  pre_q, pre_d;
    logic [31:0] count_q, count_d;
    logic        expired_q, expired_d;
    logic        tick;
    logic        hitZero;

    assign tick    = en_i && (pre_q == prescale_i);
    assign hitZero = tick && (count_q == 32'd0);

    always_comb begin
        pre_d     = pre_q;
        count_d   = count_q;
        expired_d = expired_q;
        enClr_o   = 1'b0;

        // A fresh enable always starts a full prescale period
        if (enRise_i) begin
            pre_d = 8'd0;
        end else if (en_i) begin
            pre_d = tick ? 8'd0 : pre_q + 8'd1;
        end

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (autoReload_i) begin
                count_d = load_i;
            end else begin
                enClr_o = 1'b1;
            end
        end else if (!en_i) begin
            // While stopped, LOAD writes are mirrored into COUNT
            count_d = mergeBytes(count_q, loadWdata_i, loadStrb_i);
        end

        // Hardware set wins over a same-cycle software clear
        if (expiredClr_i) begin
            expired_d = 1'b0;
        end
        if (hitZero) begin
            expired_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pre_q     <= 8'd0;
            count_q   <= 32'd0;
            expired_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = expired_q;

endmodule

// File: rtl/apb_timer.sv
// ----------------------------------------------------------------------------
// apb_timer
// APB3/4 slave wrapping a 32-bit prescaled down-counter timer. Handles the
// APB handshake with WAIT_CYCLES access-phase wait states, register decode,
// the CTRL/LOAD register file, the read mux and the level interrupt.
// Ports:
//   APB_clk, APB_rst_n   clock, synchronous active-low reset
//   PSEL, PENABLE        APB select / access phase
//   PADDR, PWRITE        byte address, write flag
//   PWDATA, PSTRB        write data and byte enables
//   PPROT                protection attributes (not used)
//   prdata, pready       read data, transfer complete (registered)
//   pslverr              transfer error, valid with pready
//   irq                  registered EXPIRED & IRQ_EN
// ----------------------------------------------------------------------------
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int DATASIZE    = 32,
    parameter int ADDRSIZE    = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    APB_clk,
    input  logic                    APB_rst_n,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [ADDRSIZE-1:0]     PADDR,
    input  logic                    PWRITE,
    input  logic [DATASIZE-1:0]     PWDATA,
    input  logic [DATASIZE/8-1:0]   PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATASIZE-1:0]     prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic                    irq
);

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] prdata_q, prdata_d;
    logic [2:0]  waitCnt_q, waitCnt_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d;
    logic        irq_q;

    logic [3:0]  offset;
    logic        accessErr;
    logic [31:0] readData;
    logic        writeCommit;
    logic        ctrlWr, loadWr, statusWr;
    logic        enRise, enClr, expiredClr;
    logic [31:0] count;
    logic        expired;
    logic        unusedPprot;

    assign unusedPprot = ^PPROT;

    // The bridge presents a peripheral-relative address, so anything above
    // the four-register window (upper bits set) is an error.
    assign offset    = PADDR[3:0];
    assign accessErr = (offset[1:0] != 2'b00) || (PADDR[ADDRSIZE-1:4] != '0) ||
                       (PWRITE && (offset == OFF_COUNT));

    always_comb begin
        readData = 32'd0;
        case (offset)
            OFF_CTRL:   readData = ctrlToWord(ctrl_q);
            OFF_LOAD:   readData = load_q;
            OFF_COUNT:  readData = count;
            OFF_STATUS: readData[STATUS_EXP_BIT] = expired;
            default:    readData = 32'd0;
        endcase
    end

    // Handshake: pready is raised one edge ahead so it is high in the access
    // cycle after WAIT_CYCLES low ones; read data and error are captured on
    // that same edge so they are valid throughout the pready cycle.
    always_comb begin
        pready_d  = 1'b0;
        waitCnt_d = waitCnt_q;
        if (!PSEL) begin
            waitCnt_d = 3'd0;
        end else if (!PENABLE) begin
            waitCnt_d = 3'd0;
            pready_d  = (WAIT_CYCLES == 0);
        end else if (pready_q) begin
            waitCnt_d = 3'd0;
        end else if ((WAIT_CYCLES == 0) || (waitCnt_q == WAIT_LAST)) begin
            pready_d = 1'b1;
        end else begin
            waitCnt_d = waitCnt_q + 3'd1;
        end

        prdata_d  = 32'd0;
        pslverr_d = 1'b0;
        if (pready_d) begin
            pslverr_d = accessErr;
            if (!PWRITE && !accessErr) begin
                prdata_d = readData;
            end
        end
    end

    // Writes commit at the end of the pready cycle, using the error decision
    // already presented to the bridge.
    assign writeCommit = PSEL && PENABLE && pready_q && PWRITE && !pslverr_q;
    assign ctrlWr      = writeCommit && (offset == OFF_CTRL);
    assign loadWr      = writeCommit && (offset == OFF_LOAD);
    assign statusWr    = writeCommit && (offset == OFF_STATUS);
    assign expiredClr  = statusWr && PSTRB[0] && PWDATA[STATUS_EXP_BIT];

    // A one-shot expiry clearing EN overrides any same-cycle software value
    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrlWr) begin
            if (PSTRB[0]) begin
                ctrl_d.en         = PWDATA[CTRL_EN_BIT];
                ctrl_d.autoReload = PWDATA[CTRL_AR_BIT];
                ctrl_d.irqEn      = PWDATA[CTRL_IRQ_BIT];
            end
            if (PSTRB[1]) begin
                ctrl_d.prescale = PWDATA[CTRL_PS_LSB +: 8];
            end
        end
        if (enClr) begin
            ctrl_d.en = 1'b0;
        end
    end

    assign enRise = ctrlWr && !ctrl_q.en && ctrl_d.en;
    assign load_d = loadWr ? mergeBytes(load_q, PWDATA, PSTRB) : load_q;

    always_ff @(posedge APB_clk) begin
        if (!APB_rst_n) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'd0;
            waitCnt_q <= 3'd0;
            ctrl_q    <= '0;
            load_q    <= 32'd0;
            irq_q     <= 1'b0;
        end else begin
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            waitCnt_q <= waitCnt_d;
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            irq_q     <= expired && ctrl_q.irqEn;
        end
    end

    apb_timer_core u_core (
        .clk_i        (APB_clk),
        .rst_ni       (APB_rst_n),
        .en_i         (ctrl_q.en),
        .autoReload_i (ctrl_q.autoReload),
        .prescale_i   (ctrl_q.prescale),
        .load_i       (load_q),
        .loadStrb_i   (loadWr ? PSTRB : 4'b0000),
        .loadWdata_i  (PWDATA),
        .enRise_i     (enRise),
        .expiredClr_i (expiredClr),
        .count_o      (count),
        .expired_o    (expired),
        .enClr_o      (enClr)
    );

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign irq     = irq_q;

endmodule
